// File: rtl/pe_mac_array_lane.sv
// pe_mac_array_lane: LANES-wide signed MAC with a 2-stage pipeline, CHAIN pass-through or local ACCUM groups,
// valid/ready on both sides and optional output saturation.
module pe_mac_array_lane #(
   parameter int IFM_WIDTH  = 8,
   parameter int WGT_WIDTH  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int ACC_LEN_W  = 8,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [LANES*IFM_WIDTH-1:0]    i_ifm,
   input  logic [LANES*WGT_WIDTH-1:0]    i_wgt,
   input  logic signed [DATA_WIDTH-1:0]  i_psum_in,
   input  logic                          i_mode,
   input  logic [ACC_LEN_W-1:0]          i_acc_len,
   input  logic                          i_clear,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic signed [DATA_WIDTH-1:0]  o_psum_out,
   output logic                          o_sat_flag
);
   localparam int PW    = IFM_WIDTH + WGT_WIDTH;
   localparam int AW0   = PW + $clog2(LANES) + ACC_LEN_W + 1;
   localparam int ACC_W = AW0 > DATA_WIDTH ? AW0 : DATA_WIDTH + 1;
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
   typedef enum logic {S_IDLE, S_ACC} state_t;
   state_t                       r_state;
   logic [ACC_LEN_W-1:0]         r_len, r_cnt;
   logic                         r_s1_valid, r_s1_first, r_s1_last;
   logic signed [PW-1:0]         r_prod [LANES];
   logic signed [DATA_WIDTH-1:0] r_s1_psum, r_psum_out, w_out;
   logic signed [ACC_W-1:0]      r_acc, w_sum, w_acc_nxt;
   logic                         r_out_valid, r_sat;
   logic                         w_adv, w_acc_in, w_first, w_last, w_s1_chain, w_s2_go, w_hi, w_lo;
   assign w_adv      = !r_out_valid | i_out_ready;
   assign o_in_ready = w_adv & !rst;
   assign w_acc_in   = i_in_valid & o_in_ready;
   assign w_first    = r_state == S_IDLE;
   assign w_last     = w_first ? (!i_mode || i_acc_len <= ACC_LEN_W'(1)) : (r_cnt == r_len - ACC_LEN_W'(1));
   // A self-contained (first & last) beat in stage 1 survives clear; partial ACCUM beats are dropped.
   assign w_s1_chain = r_s1_first & r_s1_last;
   assign w_s2_go    = w_adv & r_s1_valid & (!i_clear | w_s1_chain);
   always_comb begin
      w_sum = '0;
      for (int l = 0; l < LANES; l++) w_sum = w_sum + ACC_W'(r_prod[l]);
   end
   assign w_acc_nxt = (r_s1_first ? ACC_W'(r_s1_psum) : r_acc) + w_sum;
   assign w_hi      = w_acc_nxt > MAXV;
   assign w_lo      = w_acc_nxt < MINV;
   assign w_out     = !SATURATE ? w_acc_nxt[DATA_WIDTH-1:0] :
                      w_hi ? MAXV[DATA_WIDTH-1:0] : w_lo ? MINV[DATA_WIDTH-1:0] : w_acc_nxt[DATA_WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (w_acc_in) begin
         for (int l = 0; l < LANES; l++)
            r_prod[l] <= $signed(i_ifm[l*IFM_WIDTH +: IFM_WIDTH]) * $signed(i_wgt[l*WGT_WIDTH +: WGT_WIDTH]);
         r_s1_psum  <= i_psum_in;
         r_s1_first <= w_first;
         r_s1_last  <= w_last;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_s1_valid  <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_psum_out  <= '0;
         r_sat       <= 1'b0;
      end else begin
         if (i_clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else if (w_acc_in) begin
            if (w_first && !w_last) begin
               r_state <= S_ACC;
               r_len   <= i_acc_len;
               r_cnt   <= ACC_LEN_W'(1);
            end else if (!w_first) begin
               r_state <= w_last ? S_IDLE : S_ACC;
               r_cnt   <= r_cnt + 1'b1;
            end
         end
         r_s1_valid <= (w_acc_in & !i_clear) | (r_s1_valid & !w_adv & (!i_clear | w_s1_chain));
         if (w_s2_go) r_acc <= w_acc_nxt;
         if (w_s2_go && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_psum_out  <= w_out;
            r_sat       <= w_hi | w_lo;
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end
   assign o_out_valid = r_out_valid;
   assign o_psum_out  = r_psum_out;
   assign o_sat_flag  = r_sat;
endmodule

// File: tb/tb_pe_mac_array_lane.sv
// tb_pe_mac_array_lane: directed scenarios against a saturating and a wrapping instance sharing one stimulus.
module tb_pe_mac_array_lane;
   localparam logic [31:0] F1 = 32'h04030201;
   localparam logic [31:0] W1 = 32'h08070605;
   logic               clk = 1'b0, rst = 1'b1;
   logic               i_in_valid = 1'b0, i_mode = 1'b0, i_clear = 1'b0, i_out_ready = 1'b1;
   logic [31:0]        i_ifm = '0, i_wgt = '0;
   logic signed [15:0] i_psum_in = '0;
   logic [7:0]         i_acc_len = '0;
   logic               o_in_ready, o_out_valid, o_sat_flag;
   logic signed [15:0] o_psum_out;
   logic               w_in_ready, w_out_valid, w_sat_flag;
   logic signed [15:0] w_psum_out;
   int                 vectors = 0, miscompares = 0, cyc = 0, hold_err = 0;
   logic               stall_seen = 1'b0, prev_hold = 1'b0;
   logic signed [15:0] prev_val = '0;
   logic signed [15:0] q_val[$];
   logic               q_sat[$];
   int                 q_cyc[$];

   pe_mac_array_lane u_dut (
      .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_ifm(i_ifm), .i_wgt(i_wgt),
      .i_psum_in(i_psum_in), .i_mode(i_mode), .i_acc_len(i_acc_len), .i_clear(i_clear),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_psum_out(o_psum_out), .o_sat_flag(o_sat_flag));
   pe_mac_array_lane #(.SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .o_in_ready(w_in_ready), .i_ifm(i_ifm), .i_wgt(i_wgt),
      .i_psum_in(i_psum_in), .i_mode(i_mode), .i_acc_len(i_acc_len), .i_clear(i_clear),
      .o_out_valid(w_out_valid), .i_out_ready(i_out_ready), .o_psum_out(w_psum_out), .o_sat_flag(w_sat_flag));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (o_out_valid && i_out_ready) begin
         q_val.push_back(o_psum_out);
         q_sat.push_back(o_sat_flag);
         q_cyc.push_back(cyc);
      end
      if (prev_hold && o_psum_out !== prev_val) hold_err++;
      if (o_out_valid && !i_out_ready && !o_in_ready) stall_seen = 1'b1;
      prev_hold = o_out_valid && !i_out_ready;
      prev_val  = o_psum_out;
   end

   task automatic clear_q();
      q_val.delete();
      q_sat.delete();
      q_cyc.delete();
   endtask

   task automatic beat(input logic [31:0] f, input logic [31:0] w, input logic signed [15:0] p,
                       input logic m, input logic [7:0] len, input logic clr);
      int n = 0;
      i_in_valid = 1'b1; i_ifm = f; i_wgt = w; i_psum_in = p; i_mode = m; i_acc_len = len; i_clear = clr;
      @(negedge clk);
      while (!o_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL beat_accept: in_ready stuck low for %0d cycles, required 1", n);
      end
      @(posedge clk); #1;
      i_in_valid = 1'b0; i_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      i_in_valid = 1'b0; i_clear = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_q(input int n);
      int t = 0;
      while (q_val.size() < n && t < 40) begin
         @(posedge clk);
         t++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready_low: got %b required 0", o_in_ready); end
      rst = 1'b0; #1;
      vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b required 1", o_in_ready); end
      vectors++; if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b required 0", o_out_valid); end
      vectors++; if (o_psum_out !== 16'sd0) begin miscompares++; $display("FAIL rst_psum: got %0d required 0", o_psum_out); end
      vectors++; if (o_sat_flag !== 1'b0) begin miscompares++; $display("FAIL rst_sat: got %b required 0", o_sat_flag); end
      @(posedge clk); #1;
   endtask

   task automatic test_chain();
      int k;
      clear_q();
      beat(F1, W1, 16'sd10, 1'b0, 8'd0, 1'b0);
      k = cyc;
      @(negedge clk);
      vectors++; if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL chain_early: out_valid %b one cycle after accept, required 0", o_out_valid); end
      @(negedge clk);
      vectors++; if (o_out_valid !== 1'b1) begin miscompares++; $display("FAIL chain_valid: got %b required 1", o_out_valid); end
      vectors++; if (o_psum_out !== 16'sd80) begin miscompares++; $display("FAIL chain_psum: got %0d required 80", o_psum_out); end
      vectors++; if (o_sat_flag !== 1'b0) begin miscompares++; $display("FAIL chain_sat: got %b required 0", o_sat_flag); end
      vectors++; if (w_psum_out !== 16'sd80 || w_sat_flag !== 1'b0) begin miscompares++; $display("FAIL chain_wrap: got %0d/%b required 80/0", w_psum_out, w_sat_flag); end
      idle(4);
      vectors++; if (q_val.size() != 1 || q_cyc[0] != k + 1) begin miscompares++; $display("FAIL chain_once: got %0d results required 1 at cycle %0d", q_val.size(), k + 1); end
   endtask

   task automatic test_saturation();
      beat(32'h7F7F7F7F, 32'h7F7F7F7F, 16'sd32767, 1'b0, 8'd0, 1'b0);
      @(negedge clk); @(negedge clk);
      vectors++; if (o_psum_out !== 16'sh7FFF || o_sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_pos: got %0d/%b required 32767/1", o_psum_out, o_sat_flag); end
      vectors++; if (w_psum_out !== 16'sh7C03 || w_sat_flag !== 1'b1) begin miscompares++; $display("FAIL wrap_pos: got %h/%b required 7c03/1", w_psum_out, w_sat_flag); end
      @(posedge clk); #1;
      beat(32'h80808080, 32'h7F7F7F7F, -16'sd32768, 1'b0, 8'd0, 1'b0);
      @(negedge clk); @(negedge clk);
      vectors++; if (o_psum_out !== 16'sh8000 || o_sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_neg: got %0d/%b required -32768/1", o_psum_out, o_sat_flag); end
      vectors++; if (w_psum_out !== 16'sh8200 || w_sat_flag !== 1'b1) begin miscompares++; $display("FAIL wrap_neg: got %h/%b required 8200/1", w_psum_out, w_sat_flag); end
      idle(4);
   endtask

   task automatic test_accum();
      int k;
      clear_q();
      beat(F1, W1, 16'sd100, 1'b1, 8'd3, 1'b0);
      beat(F1, W1, 16'sd9999, 1'b0, 8'd1, 1'b0);
      beat(F1, W1, 16'sd9999, 1'b0, 8'd1, 1'b0);
      k = cyc;
      wait_q(1);
      idle(4);
      vectors++; if (q_val.size() != 1) begin miscompares++; $display("FAIL accum_count: got %0d results required 1", q_val.size()); end
      else begin
         vectors++; if (q_val[0] !== 16'sd310 || q_sat[0] !== 1'b0) begin miscompares++; $display("FAIL accum_sum: got %0d/%b required 310/0", q_val[0], q_sat[0]); end
         vectors++; if (q_cyc[0] != k + 1) begin miscompares++; $display("FAIL accum_latency: got cycle %0d required %0d", q_cyc[0], k + 1); end
      end
      clear_q();
      beat(F1, W1, 16'sd5, 1'b1, 8'd0, 1'b0);
      beat(F1, W1, 16'sd1, 1'b1, 8'd0, 1'b0);
      wait_q(2);
      idle(4);
      vectors++; if (q_val.size() != 2) begin miscompares++; $display("FAIL len0_count: got %0d results required 2", q_val.size()); end
      else begin
         vectors++; if (q_val[0] !== 16'sd75 || q_val[1] !== 16'sd71) begin miscompares++; $display("FAIL len0_vals: got %0d,%0d required 75,71", q_val[0], q_val[1]); end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      hold_err = 0; stall_seen = 1'b0; i_out_ready = 1'b1;
      fork
         begin
            repeat (3) @(posedge clk);
            #2 i_out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2 i_out_ready = 1'b1;
         end
      join_none
      for (int k = 1; k <= 8; k++) beat(32'(k), 32'h1, 16'(100 * k), 1'b0, 8'd0, 1'b0);
      wait_q(8);
      idle(4);
      vectors++; if (q_val.size() != 8) begin miscompares++; $display("FAIL b2b_count: got %0d results required 8", q_val.size()); end
      for (int i = 0; i < q_val.size() && i < 8; i++) begin
         vectors++; if (q_val[i] !== 16'(101 * (i + 1))) begin miscompares++; $display("FAIL b2b_val%0d: got %0d required %0d", i, q_val[i], 101 * (i + 1)); end
      end
      vectors++; if (stall_seen !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_drop: got %b required 1", stall_seen); end
      vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL b2b_hold: got %0d changes while stalled required 0", hold_err); end
   endtask

   task automatic test_clear();
      clear_q();
      i_out_ready = 1'b1;
      beat(F1, W1, 16'sd500, 1'b1, 8'd4, 1'b0);
      beat(F1, W1, 16'sd500, 1'b1, 8'd4, 1'b0);
      beat(F1, W1, 16'sd777, 1'b0, 8'd0, 1'b1);
      beat(F1, W1, 16'sd0, 1'b1, 8'd2, 1'b0);
      beat(F1, W1, 16'sd9999, 1'b0, 8'd7, 1'b0);
      wait_q(1);
      idle(5);
      vectors++; if (q_val.size() != 1) begin miscompares++; $display("FAIL clear_count: got %0d results required 1", q_val.size()); end
      else begin
         vectors++; if (q_val[0] !== 16'sd140) begin miscompares++; $display("FAIL clear_val: got %0d required 140", q_val[0]); end
      end
      clear_q();
      beat(F1, W1, 16'sd10, 1'b0, 8'd0, 1'b0);
      i_out_ready = 1'b0;
      beat(F1, W1, 16'sd500, 1'b1, 8'd4, 1'b0);
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0; i_out_ready = 1'b1;
      beat(F1, W1, 16'sd0, 1'b1, 8'd2, 1'b0);
      beat(F1, W1, 16'sd9999, 1'b0, 8'd0, 1'b0);
      wait_q(2);
      idle(5);
      vectors++; if (q_val.size() != 2) begin miscompares++; $display("FAIL clear_pend_count: got %0d results required 2", q_val.size()); end
      else begin
         vectors++; if (q_val[0] !== 16'sd80 || q_val[1] !== 16'sd140) begin miscompares++; $display("FAIL clear_pend_vals: got %0d,%0d required 80,140", q_val[0], q_val[1]); end
      end
   endtask

   task automatic test_async_reset();
      clear_q();
      i_out_ready = 1'b1;
      beat(F1, W1, 16'sd10, 1'b0, 8'd0, 1'b0);
      i_out_ready = 1'b0;
      beat(F1, W1, 16'sd100, 1'b1, 8'd3, 1'b0);
      vectors++; if (o_out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid: got %b required 1", o_out_valid); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (o_out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b required 0", o_out_valid); end
      vectors++; if (o_psum_out !== 16'sd0 || o_sat_flag !== 1'b0) begin miscompares++; $display("FAIL arst_out: got %0d/%b required 0/0", o_psum_out, o_sat_flag); end
      vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_in_ready: got %b required 0", o_in_ready); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      i_out_ready = 1'b1;
      beat(F1, W1, 16'sd10, 1'b0, 8'd0, 1'b0);
      @(negedge clk); @(negedge clk);
      vectors++; if (o_out_valid !== 1'b1 || o_psum_out !== 16'sd80) begin miscompares++; $display("FAIL arst_after: got %b/%0d required 1/80", o_out_valid, o_psum_out); end
      idle(5);
      vectors++; if (q_val.size() != 1) begin miscompares++; $display("FAIL arst_count: got %0d results required 1", q_val.size()); end
   endtask

   initial begin
      test_reset();
      test_chain();
      test_saturation();
      test_accum();
      test_back_to_back();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
